// File: rtl/ps2_key_if.sv
// Bundle between the PS/2 FIFO, the key decoder and its consumers
// (seg display, LEDs). The slave modport is the decoder side.
interface ps2_key_if #(
  parameter int CNT_W = 8
);
  logic [7:0]       ps2_data;
  logic             ps2_ready;
  logic             ps2_overflow;
  logic             ps2_nextdata_n;
  logic             key_down;
  logic             key_ext;
  logic [7:0]       key_code;
  logic [7:0]       key_ascii;
  logic             press_pulse;
  logic             release_pulse;
  logic [CNT_W-1:0] press_count;
  logic             overflow_err;

  modport master (
    output ps2_data, ps2_ready, ps2_overflow,
    input  ps2_nextdata_n, key_down, key_ext, key_code, key_ascii,
           press_pulse, release_pulse, press_count, overflow_err
  );

  modport slave (
    input  ps2_data, ps2_ready, ps2_overflow,
    output ps2_nextdata_n, key_down, key_ext, key_code, key_ascii,
           press_pulse, release_pulse, press_count, overflow_err
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// Pops scan-code bytes from the PS/2 FIFO, strips F0/E0 prefixes, tracks the
// single held key and counts distinct presses.
module ps2_key_decoder #(
  parameter int CNT_W = 8
) (
  input  logic      clk,
  input  logic      rst,
  ps2_key_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    POP    = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             brk_q, brk_d;
  logic             ext_q, ext_d;
  logic             down_q, down_d;
  logic             kext_q, kext_d;
  logic [7:0]       code_q, code_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;
  logic             ovf_q;
  logic             hit;

  // Scan-code set 2 to ASCII; extended keys never map.
  function automatic logic [7:0] to_ascii(input logic [7:0] code, input logic ext);
    logic [7:0] a;
    a = 8'h00;
    if (!ext) begin
      case (code)
        8'h1C: a = "A";  8'h32: a = "B";  8'h21: a = "C";  8'h23: a = "D";
        8'h24: a = "E";  8'h2B: a = "F";  8'h34: a = "G";  8'h33: a = "H";
        8'h43: a = "I";  8'h3B: a = "J";  8'h42: a = "K";  8'h4B: a = "L";
        8'h3A: a = "M";  8'h31: a = "N";  8'h44: a = "O";  8'h4D: a = "P";
        8'h15: a = "Q";  8'h2D: a = "R";  8'h1B: a = "S";  8'h2C: a = "T";
        8'h3C: a = "U";  8'h2A: a = "V";  8'h1D: a = "W";  8'h22: a = "X";
        8'h35: a = "Y";  8'h1A: a = "Z";
        8'h45: a = "0";  8'h16: a = "1";  8'h1E: a = "2";  8'h26: a = "3";
        8'h25: a = "4";  8'h2E: a = "5";  8'h36: a = "6";  8'h3D: a = "7";
        8'h3E: a = "8";  8'h46: a = "9";
        8'h29: a = 8'h20;
        default: a = 8'h00;
      endcase
    end
    return a;
  endfunction

  assign hit = down_q && (bus.ps2_data == code_q) && (ext_q == kext_q);

  always_comb begin
    state_d = state_q;
    brk_d   = brk_q;
    ext_d   = ext_q;
    down_d  = down_q;
    kext_d  = kext_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.ps2_ready) begin
          state_d = POP;
          if (bus.ps2_data == 8'hF0) begin
            brk_d = 1'b1;
          end else if (bus.ps2_data == 8'hE0) begin
            ext_d = 1'b1;
          end else begin
            if (brk_q) begin
              if (hit) begin
                down_d = 1'b0;
                rel_d  = 1'b1;
              end
              brk_d = 1'b0;
            end else if (!hit) begin
              // Any make that is not a typematic repeat of the held key is a new press.
              code_d  = bus.ps2_data;
              kext_d  = ext_q;
              down_d  = 1'b1;
              cnt_d   = cnt_q + 1'b1;
              press_d = 1'b1;
            end
            ext_d = 1'b0;
          end
        end
      end
      POP:     state_d = SETTLE;
      // FIFO read pointer is still updating; ps2_ready is not trusted here.
      SETTLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      brk_q   <= 1'b0;
      ext_q   <= 1'b0;
      down_q  <= 1'b0;
      kext_q  <= 1'b0;
      code_q  <= 8'h00;
      cnt_q   <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      brk_q   <= brk_d;
      ext_q   <= ext_d;
      down_q  <= down_d;
      kext_q  <= kext_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      ovf_q   <= ovf_q | bus.ps2_overflow;
    end
  end

  assign bus.ps2_nextdata_n = (state_q != POP);
  assign bus.key_down       = down_q;
  assign bus.key_ext        = kext_q;
  assign bus.key_code       = code_q;
  assign bus.key_ascii      = to_ascii(code_q, kext_q);
  assign bus.press_pulse    = press_q;
  assign bus.release_pulse  = rel_q;
  assign bus.press_count    = cnt_q;
  assign bus.overflow_err   = ovf_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed and randomized byte streams against a byte-level behavioural model
// of the key decoder, with a small FIFO-side handshake emulation.
module tb_ps2_key_decoder;

  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ps2_key_if #(.CNT_W(CNT_W)) bus();

  ps2_key_decoder #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int compared   = 0;
  int mismatched = 0;
  int pop_cycles = 0;

  // Reference model state
  logic       m_down, m_kext, m_brk, m_ext, m_ovf;
  logic [7:0] m_code;
  int         m_cnt;
  logic       e_press, e_rel;

  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                    8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                    8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                    8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digit_codes [10]  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                    8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] pool [8]          = '{8'h1C, 8'h16, 8'h29, 8'h75, 8'hF0, 8'hE0, 8'h45, 8'h5A};

  always @(negedge clk) if (!bus.ps2_nextdata_n) pop_cycles++;

  function automatic logic [7:0] ref_ascii(input logic [7:0] c, input logic e);
    logic [7:0] r;
    r = 8'h00;
    if (!e) begin
      for (int i = 0; i < 26; i++) if (letter_codes[i] == c) r = 8'(65 + i);
      for (int i = 0; i < 10; i++) if (digit_codes[i] == c) r = 8'(48 + i);
      if (c == 8'h29) r = 8'h20;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_down = 0; m_kext = 0; m_brk = 0; m_ext = 0; m_ovf = 0;
    m_code = 8'h00; m_cnt = 0; e_press = 0; e_rel = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic same;
    e_press = 0;
    e_rel   = 0;
    if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE0) m_ext = 1;
    else begin
      same = m_down && (b == m_code) && (m_ext == m_kext);
      if (m_brk) begin
        if (same) begin m_down = 0; e_rel = 1; end
        m_brk = 0;
      end else if (!same) begin
        m_code  = b;
        m_kext  = m_ext;
        m_down  = 1;
        m_cnt   = (m_cnt + 1) % (1 << CNT_W);
        e_press = 1;
      end
      m_ext = 0;
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".key_down"},  32'(bus.key_down),     32'(m_down));
    check({tag, ".key_ext"},   32'(bus.key_ext),      32'(m_kext));
    check({tag, ".key_code"},  32'(bus.key_code),     32'(m_code));
    check({tag, ".key_ascii"}, 32'(bus.key_ascii),    32'(ref_ascii(m_code, m_kext)));
    check({tag, ".count"},     32'(bus.press_count),  32'(m_cnt));
    check({tag, ".ovf_err"},   32'(bus.overflow_err), 32'(m_ovf));
  endtask

  // Present one byte, wait for the pop strobe, check the result and the settle cycle.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit seen;
    repeat (gap) @(negedge clk);
    model_byte(b);
    bus.ps2_data  = b;
    bus.ps2_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (!bus.ps2_nextdata_n) seen = 1;
    end
    check("pop_seen", 32'(seen), 32'd1);
    check("press_pulse", 32'(bus.press_pulse), 32'(e_press));
    check("release_pulse", 32'(bus.release_pulse), 32'(e_rel));
    check_state("pop");
    bus.ps2_ready = 1'b0;
    @(negedge clk);
    check("settle.nextdata_n", 32'(bus.ps2_nextdata_n), 32'd1);
    check("settle.pulses", 32'({bus.press_pulse, bus.release_pulse}), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.ps2_ready    = 1'b0;
    bus.ps2_overflow = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int p0;
    logic [7:0] rb;
    bus.ps2_data     = 8'h00;
    bus.ps2_ready    = 1'b0;
    bus.ps2_overflow = 1'b0;
    model_reset();

    // 1: reset values, idle with empty FIFO
    do_reset();
    check("rst.nextdata_n", 32'(bus.ps2_nextdata_n), 32'd1);
    check("rst.pulses", 32'({bus.press_pulse, bus.release_pulse}), 32'd0);
    check_state("rst");
    p0 = pop_cycles;
    repeat (5) @(negedge clk);
    check("idle.no_pop", 32'(pop_cycles - p0), 32'd0);

    // 2: press and release of A
    p0 = pop_cycles;
    send_byte(8'h1C, 0);
    check("t2.ascii_A", 32'(bus.key_ascii), 32'h41);
    send_byte(8'hF0, 0);
    send_byte(8'h1C, 0);
    check("t2.pop_cycles", 32'(pop_cycles - p0), 32'd3);
    check("t2.key_down", 32'(bus.key_down), 32'd0);

    // 3: typematic repeats are not counted
    do_reset();
    send_byte(8'h1C, 0);
    send_byte(8'h1C, 1);
    send_byte(8'h1C, 0);
    send_byte(8'hF0, 2);
    send_byte(8'h1C, 0);
    check("t3.count", 32'(bus.press_count), 32'd1);

    // 4: extended key, unmatched plain break ignored, extended break releases
    send_byte(8'hE0, 0);
    send_byte(8'h75, 0);
    check("t4.key_ext", 32'(bus.key_ext), 32'd1);
    send_byte(8'hF0, 0);
    send_byte(8'h75, 0);
    check("t4.still_down", 32'(bus.key_down), 32'd1);
    send_byte(8'hE0, 0);
    send_byte(8'hF0, 0);
    send_byte(8'h75, 0);
    check("t4.released", 32'(bus.key_down), 32'd0);

    // 5: counter wraps after 256 presses
    do_reset();
    for (int i = 0; i < 256; i++) begin
      send_byte(8'h16, 0);
      check("t5.ascii_1", 32'(bus.key_ascii), 32'h31);
      send_byte(8'hF0, 0);
      send_byte(8'h16, 0);
    end
    check("t5.wrap", 32'(bus.press_count), 32'd0);

    // Randomized byte stream with idle gaps
    do_reset();
    for (int i = 0; i < 300; i++) begin
      rb = ($urandom_range(0, 7) == 0) ? 8'($urandom) : pool[$urandom_range(0, 7)];
      send_byte(rb, $urandom_range(0, 3));
    end

    // 6: reset during POP, then sticky overflow
    send_byte(8'h1C, 0);
    send_byte(8'hF0, 0);
    send_byte(8'h1C, 0);
    bus.ps2_data  = 8'h2C;
    bus.ps2_ready = 1'b1;
    for (int i = 0; i < 8 && bus.ps2_nextdata_n; i++) @(negedge clk);
    check("t6.in_pop", 32'(bus.ps2_nextdata_n), 32'd0);
    rst = 1'b1;
    bus.ps2_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("t6.nextdata_n", 32'(bus.ps2_nextdata_n), 32'd1);
    check_state("t6");
    @(negedge clk);
    check("t6.idle", 32'(bus.ps2_nextdata_n), 32'd1);
    bus.ps2_overflow = 1'b1;
    @(negedge clk);
    bus.ps2_overflow = 1'b0;
    m_ovf = 1;
    check("t6.ovf_set", 32'(bus.overflow_err), 32'd1);
    repeat (4) @(negedge clk);
    check("t6.ovf_sticky", 32'(bus.overflow_err), 32'd1);
    send_byte(8'h29, 0);
    check("t6.space", 32'(bus.key_ascii), 32'h20);
    do_reset();
    check("t6.ovf_clr", 32'(bus.overflow_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
